// File: rtl/nios_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// nios_system_sysid_checker
//
// Reads the Nios system ID peripheral over Avalon-MM (word 0 = system ID,
// word 1 = generation timestamp) and compares both words against the values
// the software build expects. One read is in flight at a time, and the
// timestamp read is issued only after the ID response has arrived.
//
// Handshake: a read is presented with avm_read=1 and held, together with
// avm_address, until a clock edge sees avm_waitrequest=0; that edge accepts
// the read. The response is the first later clock with avm_readdatavalid=1,
// and it is accepted only while a WT_* state is waiting for it.
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   start               : check request, sampled only while idle
//   avm_address         : word address (0 = ID, 1 = timestamp), registered
//   avm_read            : read request, registered
//   avm_waitrequest     : slave stall
//   avm_readdatavalid   : read response strobe
//   avm_readdata        : read response data
//   busy                : high in every state except IDLE
//   done                : one-clock pulse in FIN (normal end or timeout)
//   pass, id_ok, ts_ok  : sticky result flags, held until the next start
//   timeout             : sticky flag, a read ran out of its clock budget
//   captured_id/_ts     : returned words, held until the next start
//   dbg_state           : current FSM state, for observation only
// -----------------------------------------------------------------------------
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_ID = 3'd1,
        WT_ID = 3'd2,
        RD_TS = 3'd3,
        WT_TS = 3'd4,
        FIN   = 3'd5
    } state_t;

    // The counter holds the number of clocks already spent on the current
    // read, so the read runs out of budget on the clock where it would
    // reach TIMEOUT_CYCLES.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic        to_hit;
    logic        abort;

    assign to_hit    = (cnt_q >= TO_LAST);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign dbg_state = state_q;

    // Next state. In RD_* an expiring budget wins over a late acceptance so
    // the request is simply dropped; in WT_* a response on the last clock
    // still counts.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RD_ID;
            end
            RD_ID: begin
                if (to_hit) begin
                    state_d = FIN;
                    abort   = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_d = WT_ID;
                end
            end
            WT_ID: begin
                if (avm_readdatavalid) begin
                    state_d = RD_TS;
                end else if (to_hit) begin
                    state_d = FIN;
                    abort   = 1'b1;
                end
            end
            RD_TS: begin
                if (to_hit) begin
                    state_d = FIN;
                    abort   = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_d = WT_TS;
                end
            end
            WT_TS: begin
                if (avm_readdatavalid) begin
                    state_d = FIN;
                end else if (to_hit) begin
                    state_d = FIN;
                    abort   = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            cnt_q       <= 16'd0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            captured_id <= 32'd0;
            captured_ts <= 32'd0;
        end else begin
            state_q     <= state_d;
            // Request lines follow the next state so they are registered
            // and stay constant for the whole RD_* stall.
            avm_read    <= (state_d == RD_ID) || (state_d == RD_TS);
            avm_address <= (state_d == RD_TS) || (state_d == WT_TS);

            if (state_q == IDLE && start) begin
                cnt_q       <= 16'd0;
                pass        <= 1'b0;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout     <= 1'b0;
                captured_id <= 32'd0;
                captured_ts <= 32'd0;
            end else if (state_q == WT_ID && avm_readdatavalid) begin
                captured_id <= avm_readdata;
                id_ok       <= (avm_readdata == EXPECTED_ID);
                cnt_q       <= 16'd0;
            end else if (state_q == WT_TS && avm_readdatavalid) begin
                captured_ts <= avm_readdata;
                ts_ok       <= (avm_readdata == EXPECTED_TS);
                // pass is ready together with the done pulse in FIN.
                pass        <= id_ok && (avm_readdata == EXPECTED_TS);
            end else if (state_q != IDLE && state_q != FIN) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (abort) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_nios_system_sysid_checker
//
// Directed bench for the system ID checker. A small Avalon slave answers
// reads from per-run settings (stall clocks, whether each word answers, the
// returned words). A run model computes from those settings when done must
// pulse and which results must be shown; one compare process checks busy,
// done and the held results on every falling edge.
// -----------------------------------------------------------------------------
module tb_nios_system_sysid_checker;

  localparam logic [31:0] EID = 32'h1234ABCD;
  localparam logic [31:0] ETS = 32'h5F000001;
  localparam int          TO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] captured_id, captured_ts;
  logic [2:0]  dbg_state;

  // slave side
  logic        s_rdv = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        f_rdv;
  logic [31:0] f_data;
  int          cfg_wait;
  bit          cfg_resp_id, cfg_resp_ts;
  logic [31:0] cfg_id, cfg_ts;
  int          stall_cnt = 0;
  bit          resp_due = 1'b0;
  bit          resp_en = 1'b0;
  logic [31:0] resp_dat = 32'd0;

  // model / scoreboard state
  int          cyc = 0;
  int          cyc0;
  int          exp_done;
  logic        e_pass, e_id_ok, e_ts_ok, e_tmo;
  logic [31:0] e_cid, e_cts;
  int          total = 0;
  int          bad = 0;
  bit          in_run;
  logic        prev_read = 1'b0, prev_wait = 1'b0, prev_addr = 1'b0;

  assign avm_readdatavalid = s_rdv | f_rdv;
  assign avm_readdata      = f_rdv ? f_data : s_data;

  nios_system_sysid_checker #(
    .EXPECTED_ID   (EID),
    .EXPECTED_TS   (ETS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock            (clk),
    .reset            (reset),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata     (avm_readdata),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .id_ok            (id_ok),
    .ts_ok            (ts_ok),
    .timeout          (timeout),
    .captured_id      (captured_id),
    .captured_ts      (captured_ts),
    .dbg_state        (dbg_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Run model: each read costs wait+2 clocks (stall, accept, response) when
  // it answers within the budget, otherwise the full budget of TO clocks.
  // done shows 1 + read1 + read2 clocks after start is presented.
  task automatic model(input int w, input bit rid, input bit rts,
                       input logic [31:0] idd, input logic [31:0] tsd,
                       output int lat, output logic p, output logic io,
                       output logic tso, output logic tmo,
                       output logic [31:0] cid, output logic [31:0] cts);
    bit ok1, ok2;
    int t1, t2;
    ok1 = rid && (w + 2 <= TO);
    ok2 = ok1 && rts && (w + 2 <= TO);
    t1  = ok1 ? w + 2 : TO;
    t2  = ok1 ? (ok2 ? w + 2 : TO) : 0;
    lat = 1 + t1 + t2;
    io  = ok1 && (idd == EID);
    tso = ok2 && (tsd == ETS);
    p   = io && tso;
    tmo = !ok2;
    cid = ok1 ? idd : 32'd0;
    cts = ok2 ? tsd : 32'd0;
  endtask

  // Avalon slave: decides at each falling edge what the next rising edge sees.
  always @(negedge clk) begin
    s_rdv = 1'b0;
    if (reset) begin
      avm_waitrequest = 1'b0;
      stall_cnt = 0;
      resp_due = 1'b0;
    end else begin
      if (resp_due) begin
        resp_due = 1'b0;
        s_rdv    = resp_en;
        s_data   = resp_dat;
      end
      if (avm_read) begin
        if (stall_cnt < cfg_wait) begin
          avm_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          avm_waitrequest = 1'b0;
          stall_cnt = 0;
          resp_due  = 1'b1;
          resp_en   = avm_address ? cfg_resp_ts : cfg_resp_id;
          resp_dat  = avm_address ? cfg_ts : cfg_id;
        end
      end else begin
        avm_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    #1;
    in_run = (cyc >= cyc0) && (cyc <= exp_done);
    if (in_run) begin
      chk("busy_run", busy, cyc > cyc0);
      chk("done_run", done, cyc == exp_done);
      if (cyc == exp_done) begin
        chk("pass", pass, e_pass);
        chk("id_ok", id_ok, e_id_ok);
        chk("ts_ok", ts_ok, e_ts_ok);
        chk("timeout", timeout, e_tmo);
        chk("captured_id", captured_id, e_cid);
        chk("captured_ts", captured_ts, e_cts);
        chk("read_at_done", avm_read, 1'b0);
      end
    end else begin
      chk("busy_idle", busy, 1'b0);
      chk("done_idle", done, 1'b0);
      chk("hold_pass", pass, e_pass);
      chk("hold_id_ok", id_ok, e_id_ok);
      chk("hold_ts_ok", ts_ok, e_ts_ok);
      chk("hold_timeout", timeout, e_tmo);
      chk("hold_cid", captured_id, e_cid);
      chk("hold_cts", captured_ts, e_cts);
    end
    if (!reset && prev_read && prev_wait && !done) begin
      chk("stall_read", avm_read, 1'b1);
      chk("stall_addr", avm_address, prev_addr);
    end
    prev_read = avm_read;
    prev_wait = avm_waitrequest;
    prev_addr = avm_address;
  end

  // driver tasks
  task automatic launch(input int w, input bit rid, input bit rts,
                        input logic [31:0] idd, input logic [31:0] tsd);
    int lat;
    cfg_wait = w; cfg_resp_id = rid; cfg_resp_ts = rts; cfg_id = idd; cfg_ts = tsd;
    model(w, rid, rts, idd, tsd, lat, e_pass, e_id_ok, e_ts_ok, e_tmo, e_cid, e_cts);
    cyc0     = cyc;
    exp_done = cyc + lat;
    start    = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int g = 0;
    while (cyc < exp_done + 1 && g < 100) begin
      @(posedge clk); #3;
      g++;
    end
    if (g >= 100) begin
      total++;
      bad++;
      $display("FAIL run_bound: cyc %0d did not reach %0d", cyc, exp_done + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #3;
    end
  endtask

  initial begin
    int          lat;
    logic        p, io, tso, tmo;
    logic [31:0] cid, cts;

    reset = 1'b1; start = 1'b0; f_rdv = 1'b0; f_data = 32'd0;
    cfg_wait = 0; cfg_resp_id = 1'b1; cfg_resp_ts = 1'b1; cfg_id = 32'd0; cfg_ts = 32'd0;
    e_pass = 0; e_id_ok = 0; e_ts_ok = 0; e_tmo = 0; e_cid = 0; e_cts = 0;
    cyc0 = 0; exp_done = -1;
    idle(3);
    chk("rst_read", avm_read, 1'b0);
    chk("rst_addr", avm_address, 1'b0);
    reset = 1'b0;
    idle(1);

    // hand-computed pins of the model
    model(0, 1, 1, EID, ETS, lat, p, io, tso, tmo, cid, cts);
    chk("model_lat_zero", lat, 5);
    chk("model_pass_zero", p, 1'b1);
    model(3, 1, 1, EID, ETS, lat, p, io, tso, tmo, cid, cts);
    chk("model_lat_wait3", lat, 11);
    model(0, 0, 0, EID, ETS, lat, p, io, tso, tmo, cid, cts);
    chk("model_lat_to", lat, 9);
    chk("model_tmo", tmo, 1'b1);

    // matching zero-wait slave
    launch(0, 1, 1, EID, ETS);
    wait_end();
    chk("lit_pass", pass, 1'b1);

    // wrong ID
    launch(0, 1, 1, 32'h1234ABCC, ETS);
    wait_end();
    chk("lit_cid", captured_id, 32'h1234ABCC);
    chk("lit_ts_ok", ts_ok, 1'b1);
    chk("lit_pass_bad_id", pass, 1'b0);

    // 3 clocks of waitrequest on each read
    launch(3, 1, 1, EID, ETS);
    wait_end();

    // no response at all: timeout in WT_ID
    launch(0, 0, 0, EID, ETS);
    wait_end();
    chk("lit_timeout", timeout, 1'b1);
    chk("lit_read_off", avm_read, 1'b0);

    // slave stalls forever: timeout in RD_ID
    launch(100, 1, 1, EID, ETS);
    wait_end();

    // start pulsed while busy, readdatavalid pulsed in IDLE
    launch(0, 1, 1, EID, ETS);
    idle(1);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_end();
    f_rdv = 1'b1; f_data = 32'hDEADBEEF;
    idle(1);
    f_rdv = 1'b0;
    idle(4);

    // start held through FIN (ignored) into the next IDLE clock (accepted)
    launch(0, 1, 1, EID, 32'h5F000002);
    while (cyc < exp_done) idle(1);
    start = 1'b1;
    idle(1);
    launch(0, 1, 1, EID, ETS);
    wait_end();

    // reset in WT_TS, stray response, then a fresh run
    launch(0, 1, 0, EID, ETS);
    while (cyc < cyc0 + 4) idle(1);
    chk("busy_before_rst", busy, 1'b1);
    reset = 1'b1;
    e_pass = 0; e_id_ok = 0; e_ts_ok = 0; e_tmo = 0; e_cid = 0; e_cts = 0;
    cyc0 = cyc + 1; exp_done = cyc;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_read", avm_read, 1'b0);
    chk("async_id_ok", id_ok, 1'b0);
    chk("async_cid", captured_id, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    f_rdv = 1'b1; f_data = ETS;
    idle(1);
    f_rdv = 1'b0;
    idle(5);
    launch(0, 1, 1, EID, ETS);
    wait_end();
    chk("lit_pass_after_rst", pass, 1'b1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
